msdap_frame_tx: RTL
===================

# msdap_frame_tx

Host-side serial transmitter for the MSDAP sample interface. It accepts parallel 16-bit left/right word pairs through a valid/ready handshake and drives `frame`, `inputL` and `inputR` on `dclk`, LSB first, one bit per cycle. It sequences the three stream phases: 16 Rj words, then NUM_COEFF coefficient words, then unlimited data words. It throttles on the MSDAP `inReady` output, and it is the transmitter for the MSDAP input shift registers.

## Interface
Parameters:
- WORD_W, 16, bits per serial word.
- NUM_RJ, 16, words in the Rj phase.
- NUM_COEFF, 512, words in the coefficient phase.
- MIN_GAP, 2, idle `dclk` cycles forced after each word, with `frame`=0 and data=0; legal range 0..15.
- CNT_W, 10, width of `word_cnt`; must be able to hold NUM_COEFF-1.

Ports:
- dclk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising `dclk` edge where it is sampled high.
- word_l  in  WORD_W  left-channel word to send.
- word_r  in  WORD_W  right-channel word to send.
- word_valid  in  1  `word_l`/`word_r` are valid.
- word_ready  out  1  block accepts a word this cycle.
- inReady  in  1  MSDAP ready-for-input indication.
- frame  out  1  high for exactly the first bit cycle of each word.
- inputL  out  1  serial left data.
- inputR  out  1  serial right data.
- phase  out  2  stream phase: 0 = RJ, 1 = COEFF, 2 = DATA; 3 is unused.
- word_cnt  out  CNT_W  words completed in the current phase.
- busy  out  1  high in SHIFT or GAP.

## Operation
States: IDLE, SHIFT, GAP.

IDLE:
- `word_ready` = `inReady`.
- On `word_valid` & `word_ready`, load both words into shift registers, clear the bit counter, and go to SHIFT.

SHIFT:
- `inputL`/`inputR` = bit 0 of the shift registers; the registers shift right one bit per cycle.
- `frame` = 1 only while the bit counter is 0.
- After bit WORD_W-1, go to GAP. If MIN_GAP = 0, go straight to IDLE.

GAP:
- Count MIN_GAP cycles with all serial outputs 0, then go to IDLE.

Phase and count:
- `word_cnt` increments in the cycle that bit WORD_W-1 is driven.
- RJ: when `word_cnt` reaches NUM_RJ-1 and a word completes, `phase` becomes 1 and `word_cnt` becomes 0.
- COEFF: the same rule applies with NUM_COEFF; `phase` becomes 2.
- DATA: `phase` stays 2 and `word_cnt` wraps modulo 2^CNT_W.

`inReady` behaviour:
- `inReady` is sampled only in IDLE.
- If `inReady` falls during SHIFT or GAP, the current word still completes; no word is aborted.

Reset:
- `reset` overrides everything, including mid-word; the block returns to IDLE.
- A word partially shifted at reset is dropped and is not counted.

## Timing
- Reset values: `word_ready`=0 in the reset cycle (it follows `inReady` from the next IDLE cycle); `frame`=0, `inputL`=0, `inputR`=0, `phase`=0, `word_cnt`=0, `busy`=0.
- All outputs are registered except `word_ready`, which is combinational from state and `inReady`.
- Latency: handshake in cycle T gives `frame`=1 and bit 0 in cycle T+1; bit k appears in cycle T+1+k.
- Minimum word period is WORD_W + MIN_GAP + 1 cycles (19 at defaults). The single IDLE cycle is mandatory, so frames are never back-to-back.
- `frame` and bit 0 are coincident. The receiver latches bits on the following 16 `dclk` rising edges, so data changes only on `dclk` rising edges.
- Simultaneous phase rollover and handshake: a word accepted in the same cycle as a rollover is counted in the new phase.
- `word_valid` held with `inReady`=0 causes no transfer; the held word may change freely until accepted.

## Test plan
- Reset behaviour -> hold `reset` 3 cycles with `word_valid`=1 and `inReady`=1 -> all outputs 0 and no `frame` during reset; first handshake occurs on the first cycle after reset.
- Single word -> `word_l`=0xA5C3, `word_r`=0x0001 -> `frame` high for 1 cycle. `inputL` = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 and `inputR` = 1 then fifteen 0s; `word_cnt`=1 after completion.
- Back-to-back -> continuous `word_valid` at defaults -> `frame` rising edges exactly 19 cycles apart; GAP cycles show all outputs 0.
- Phase sequencing -> send 16 + 512 + 3 words -> `phase` becomes 1 after word 16 and 2 after word 528; `word_cnt`=3 at the end in DATA.
- `inReady` throttle -> drop `inReady` at bit 5 of a word and hold it low 40 cycles -> current word completes all 16 bits; no new `frame` until 1 cycle after `inReady` returns high.
- Reset mid-word -> assert `reset` at bit 8 of word 10 in RJ -> serial outputs 0 next cycle, `phase`=0, `word_cnt`=0; the next word sends from bit 0 with `frame`.

Source files
------------

// File: rtl/msdap_frame_tx.sv
// Host-side serial transmitter for the MSDAP sample interface: accepts L/R word
// pairs on a valid/ready handshake and shifts them out LSB first behind a frame strobe.
module msdap_frame_tx #(
  parameter int WORD_W    = 16,
  parameter int NUM_RJ    = 16,
  parameter int NUM_COEFF = 512,
  parameter int MIN_GAP   = 2,
  parameter int CNT_W     = 10
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_l,
  input  logic [WORD_W-1:0] word_r,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              inReady,
  output logic              frame,
  output logic              inputL,
  output logic              inputR,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [3:0]       LAST_GAP = 4'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] RJ_LAST  = CNT_W'(NUM_RJ - 1);
  localparam logic [CNT_W-1:0] CO_LAST  = CNT_W'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sh_l;
  logic [WORD_W-1:0] sh_r;
  logic [WORD_W-1:0] sh_l_nxt;
  logic [WORD_W-1:0] sh_r_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_nxt;
  logic [3:0]        gap_cnt;
  logic [3:0]        gap_cnt_nxt;
  logic              frame_nxt;
  logic              l_nxt;
  logic              r_nxt;
  logic              word_done;
  logic              accept;
  logic [1:0]        phase_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Ready is only offered from IDLE, and never in a cycle where reset is sampled.
  assign word_ready = (state == IDLE) && inReady && !reset;
  assign accept     = word_valid && word_ready;

  // Serial sequencer; the output flops carry the bit being driven, so bit 0 is
  // launched straight from the input word on the handshake edge.
  always_comb begin
    state_nxt   = state;
    sh_l_nxt    = sh_l;
    sh_r_nxt    = sh_r;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    frame_nxt   = 1'b0;
    l_nxt       = 1'b0;
    r_nxt       = 1'b0;
    word_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = SHIFT;
          sh_l_nxt    = word_l >> 1;
          sh_r_nxt    = word_r >> 1;
          bit_cnt_nxt = '0;
          frame_nxt   = 1'b1;
          l_nxt       = word_l[0];
          r_nxt       = word_r[0];
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          word_done   = 1'b1;
          gap_cnt_nxt = 4'd0;
          state_nxt   = (MIN_GAP == 0) ? IDLE : GAP;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          l_nxt       = sh_l[0];
          r_nxt       = sh_r[0];
          sh_l_nxt    = sh_l >> 1;
          sh_r_nxt    = sh_r >> 1;
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stream phase tracking: RJ -> COEFF -> DATA, the count restarting at each rollover.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = word_cnt;
    if (word_done) begin
      case (phase)
        2'd0: begin
          if (word_cnt == RJ_LAST) begin
            phase_nxt = 2'd1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = word_cnt + CNT_W'(1);
          end
        end
        2'd1: begin
          if (word_cnt == CO_LAST) begin
            phase_nxt = 2'd2;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = word_cnt + CNT_W'(1);
          end
        end
        default: begin
          phase_nxt = 2'd2;
          cnt_nxt   = word_cnt + CNT_W'(1);
        end
      endcase
    end else begin
      phase_nxt = phase;
    end
  end

  // State, datapath and registered outputs; reset drops any word in flight.
  always_ff @(posedge dclk) begin
    if (reset) begin
      state    <= IDLE;
      sh_l     <= '0;
      sh_r     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= 4'd0;
      frame    <= 1'b0;
      inputL   <= 1'b0;
      inputR   <= 1'b0;
      phase    <= 2'd0;
      word_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh_l     <= sh_l_nxt;
      sh_r     <= sh_r_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      frame    <= frame_nxt;
      inputL   <= l_nxt;
      inputR   <= r_nxt;
      phase    <= phase_nxt;
      word_cnt <= cnt_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule
